fifo_cell_controller: RTL and testbench

FIFO_CELL_CONTROLLER -- requirements
Module: fifo_cell_controller

---
 rtl/fifo_cell_controller_pkg.sv | 23 ++
 rtl/fifo_cell_controller_token_ring.sv | 22 ++
 rtl/fifo_cell_controller.sv | 77 +++++++
 tb/tb_fifo_cell_controller.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_cell_controller_pkg.sv
// Shared constants and helpers for the FIFO cell controller and its token rings.
package fifo_cell_controller_pkg;

  // Widest ring supported by the rotate helper.
  localparam int unsigned MAX_CELLS = 64;

  // One-hot token pointing at cell 0.
  localparam logic [MAX_CELLS-1:0] TOKEN_INIT = 64'd1;

  // Bits needed to hold an occupancy count from 0 to n inclusive.
  function automatic int unsigned count_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Rotate an n-bit one-hot token one position toward the higher index, wrapping to 0.
  function automatic logic [MAX_CELLS-1:0] rotate_token(input logic [MAX_CELLS-1:0] tok,
                                                        input int unsigned n);
    logic [MAX_CELLS-1:0] mask;
    mask = (n >= MAX_CELLS) ? {MAX_CELLS{1'b1}} : ((64'd1 << n) - 64'd1);
    return ((tok << 1) | (tok >> (n - 1))) & mask;
  endfunction

endpackage

// File: rtl/fifo_cell_controller_token_ring.sv
// One-hot token rotator: advances one cell per accepted operation, resets to cell 0.
module token_ring
  import fifo_cell_controller_pkg::*;
#(
  parameter int unsigned N_CELLS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               advance,
  output logic [N_CELLS-1:0] token
);

  // Token register: reset to cell 0, rotate on advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      token <= N_CELLS'(TOKEN_INIT);
    end else if (advance) begin
      token <= N_CELLS'(rotate_token(MAX_CELLS'(token), N_CELLS));
    end
  end

endmodule

// File: rtl/fifo_cell_controller.sv
// Sequences put/get access over a ring of FIFO cells and tracks occupancy.
module fifo_cell_controller
  import fifo_cell_controller_pkg::*;
#(
  parameter int unsigned N_CELLS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             put_req,
  input  logic                             get_req,
  output logic                             put_ack,
  output logic                             get_ack,
  output logic [N_CELLS-1:0]               we_o,
  output logic [N_CELLS-1:0]               re_o,
  output logic [N_CELLS-1:0]               e_o,
  output logic                             full,
  output logic                             empty,
  output logic [count_w(N_CELLS)-1:0]      count,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int unsigned CW = count_w(N_CELLS);

  logic [N_CELLS-1:0] put_token;
  logic [N_CELLS-1:0] get_token;
  logic [N_CELLS-1:0] e_next;

  token_ring #(.N_CELLS(N_CELLS)) u_put_ring (
    .clk     (clk),
    .reset   (reset),
    .advance (put_ack),
    .token   (put_token)
  );

  token_ring #(.N_CELLS(N_CELLS)) u_get_ring (
    .clk     (clk),
    .reset   (reset),
    .advance (get_ack),
    .token   (get_token)
  );

  // Handshake and cell enables; everything is suppressed while reset is held.
  always_comb begin
    put_ack = put_req & ~full & ~reset;
    get_ack = get_req & ~empty & ~reset;
    we_o    = {N_CELLS{put_ack}} & put_token;
    re_o    = {N_CELLS{get_ack}} & get_token;
    // Put and get tokens never point at the same cell while both are acked,
    // since one targets a free cell and the other an occupied one.
    e_next  = (e_o & ~we_o) | re_o;
  end

  // Occupancy, flags and refused-request pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_o       <= {N_CELLS{1'b1}};
      empty     <= 1'b1;
      full      <= 1'b0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      e_o       <= e_next;
      empty     <= &e_next;
      full      <= ~|e_next;
      overflow  <= put_req & ~put_ack;
      underflow <= get_req & ~get_ack;
      unique case ({put_ack, get_ack})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_cell_controller.sv
// Directed self-checking bench for fifo_cell_controller with four cells.
module tb_fifo_cell_controller;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       put_req;
  logic       get_req;
  logic       put_ack;
  logic       get_ack;
  logic [3:0] we_o;
  logic [3:0] re_o;
  logic [3:0] e_o;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  int tests = 0;
  int fails = 0;

  fifo_cell_controller #(.N_CELLS(N)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .put_req   (put_req),
    .get_req   (get_req),
    .put_ack   (put_ack),
    .get_ack   (get_ack),
    .we_o      (we_o),
    .re_o      (re_o),
    .e_o       (e_o),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after the falling edge so combinational outputs can be checked before the rising edge.
  task automatic drive(input logic r, input logic p, input logic g);
    @(negedge clk);
    reset   = r;
    put_req = p;
    get_req = g;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] e, input logic [2:0] c,
                           input logic f, input logic em);
    chk({tag, "_e_o"}, 64'(e_o), 64'(e));
    chk({tag, "_count"}, 64'(count), 64'(c));
    chk({tag, "_full"}, 64'(full), 64'(f));
    chk({tag, "_empty"}, 64'(empty), 64'(em));
  endtask

  initial begin
    reset = 1'b1; put_req = 1'b0; get_req = 1'b0;

    // Reset with both requests high: no acks, clean empty state afterwards.
    drive(1'b1, 1'b1, 1'b1);
    chk("rst_put_ack", 64'(put_ack), 64'd0);
    chk("rst_get_ack", 64'(get_ack), 64'd0);
    chk("rst_we", 64'(we_o), 64'd0);
    chk("rst_re", 64'(re_o), 64'd0);
    tick();
    chk_state("rst", 4'b1111, 3'd0, 1'b0, 1'b1);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_unf", 64'(underflow), 64'd0);
    chk("rst_ptok", 64'(u_dut.u_put_ring.token), 64'h1);
    chk("rst_gtok", 64'(u_dut.u_get_ring.token), 64'h1);

    // Fill: four puts write cells 0..3 in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      chk("fill_ack", 64'(put_ack), 64'd1);
      chk("fill_we", 64'(we_o), 64'(4'b0001 << i));
      tick();
    end
    chk_state("fill", 4'b0000, 3'd4, 1'b1, 1'b0);

    // Overflow: put at full is refused and pulses overflow for one cycle.
    drive(1'b0, 1'b1, 1'b0);
    chk("ovf_put_ack", 64'(put_ack), 64'd0);
    chk("ovf_we", 64'(we_o), 64'd0);
    tick();
    chk("ovf_pulse", 64'(overflow), 64'd1);
    chk("ovf_unf", 64'(underflow), 64'd0);
    chk_state("ovf", 4'b0000, 3'd4, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    chk("ovf_clear", 64'(overflow), 64'd0);
    chk_state("ovf_idle", 4'b0000, 3'd4, 1'b1, 1'b0);

    // Simultaneous at full: only the get is taken.
    drive(1'b0, 1'b1, 1'b1);
    chk("simf_get_ack", 64'(get_ack), 64'd1);
    chk("simf_put_ack", 64'(put_ack), 64'd0);
    chk("simf_re", 64'(re_o), 64'h1);
    tick();
    chk_state("simf", 4'b0001, 3'd3, 1'b0, 1'b0);
    chk("simf_ovf", 64'(overflow), 64'd1);

    // Single get brings count to 2.
    drive(1'b0, 1'b0, 1'b1);
    chk("get2_re", 64'(re_o), 64'h2);
    tick();
    chk_state("get2", 4'b0011, 3'd2, 1'b0, 1'b0);

    // Simultaneous at count 2: both acked, count holds.
    drive(1'b0, 1'b1, 1'b1);
    chk("sim2_put_ack", 64'(put_ack), 64'd1);
    chk("sim2_get_ack", 64'(get_ack), 64'd1);
    chk("sim2_we", 64'(we_o), 64'h1);
    chk("sim2_re", 64'(re_o), 64'h4);
    tick();
    chk_state("sim2", 4'b0110, 3'd2, 1'b0, 1'b0);
    chk("sim2_ovf", 64'(overflow), 64'd0);
    chk("sim2_unf", 64'(underflow), 64'd0);

    // Drain the last two cells (get token wraps from cell 3 to cell 0).
    drive(1'b0, 1'b0, 1'b1);
    chk("drain_re3", 64'(re_o), 64'h8);
    tick();
    drive(1'b0, 1'b0, 1'b1);
    chk("drain_re0", 64'(re_o), 64'h1);
    tick();
    chk_state("drain", 4'b1111, 3'd0, 1'b0, 1'b1);

    // Underflow at empty with simultaneous put.
    drive(1'b0, 1'b1, 1'b1);
    chk("unf_put_ack", 64'(put_ack), 64'd1);
    chk("unf_get_ack", 64'(get_ack), 64'd0);
    chk("unf_we", 64'(we_o), 64'h2);
    chk("unf_re", 64'(re_o), 64'h0);
    tick();
    chk_state("unf", 4'b1101, 3'd1, 1'b0, 1'b0);
    chk("unf_pulse", 64'(underflow), 64'd1);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    chk("unf_clear", 64'(underflow), 64'd0);

    // Reach count 3, then reset mid-traffic with put_req high.
    drive(1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0);
    tick();
    chk_state("pre_rst", 4'b0001, 3'd3, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    chk("mrst_put_ack", 64'(put_ack), 64'd0);
    chk("mrst_we", 64'(we_o), 64'd0);
    tick();
    chk_state("mrst", 4'b1111, 3'd0, 1'b0, 1'b1);
    chk("mrst_ptok", 64'(u_dut.u_put_ring.token), 64'h1);
    chk("mrst_gtok", 64'(u_dut.u_get_ring.token), 64'h1);

    // Wrap: six put/get pairs from fresh; both tokens end at cell 2.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      chk("wrap_we", 64'(we_o), 64'(4'b0001 << (i % 4)));
      tick();
      drive(1'b0, 1'b0, 1'b1);
      chk("wrap_re", 64'(re_o), 64'(4'b0001 << (i % 4)));
      tick();
    end
    chk_state("wrap", 4'b1111, 3'd0, 1'b0, 1'b1);
    chk("wrap_ptok", 64'(u_dut.u_put_ring.token), 64'h4);
    chk("wrap_gtok", 64'(u_dut.u_get_ring.token), 64'h4);

    drive(1'b0, 1'b0, 1'b0);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
